display_timing: RTL and testbench

Generates 640x480 @ 60 Hz VGA raster timing from the 100 MHz system clock. It drives `hSync`/`vSync` to the connector and `hCount`, `vCount` and `bright` to the pixel-colour logic, which consumes them to produce `rgb`. A once-per-frame `frame_tick` strobe serves as the game-logic update clock enable, replacing ad-hoc slow clocks.

---
 rtl/display_timing.sv | 71 +++++++
 tb/tb_display_timing.sv | 134 +++++++++++++
 2 files changed

// File: rtl/display_timing.sv
// VGA raster timing: pixel prescaler, h/v counters and registered sync/bright decode.
// Decoded outputs are computed from next-state counters so they change on the same edge as hCount/vCount.
module display_timing #(
    parameter int CLK_DIV  = 4,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       pix_en,
    output logic       frame_tick
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(CLK_DIV - 1);
    localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
    localparam int H_VIS_LO = H_SYNC + H_BP;
    localparam int H_VIS_HI = H_SYNC + H_BP + H_ACTIVE;
    localparam int V_VIS_LO = V_SYNC + V_BP;
    localparam int V_VIS_HI = V_SYNC + V_BP + V_ACTIVE;

    logic [PW-1:0] presc;
    logic [9:0]    h_nxt, v_nxt;

    // Gated by rst so the strobe stays low in reset even when CLK_DIV=1.
    assign pix_en     = rst & (presc == PS_MAX);
    assign frame_tick = pix_en & (hCount == H_MAX) & (vCount == V_MAX);

    always_comb begin
        h_nxt = hCount;
        v_nxt = vCount;
        if (pix_en) begin
            if (hCount == H_MAX) begin
                h_nxt = '0;
                v_nxt = (vCount == V_MAX) ? 10'd0 : vCount + 10'd1;
            end else begin
                h_nxt = hCount + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc  <= '0;
            hCount <= '0;
            vCount <= '0;
            hSync  <= 1'b0;
            vSync  <= 1'b0;
            bright <= 1'b0;
        end else begin
            presc  <= (presc == PS_MAX) ? '0 : presc + PW'(1);
            hCount <= h_nxt;
            vCount <= v_nxt;
            hSync  <= int'(h_nxt) >= H_SYNC;
            vSync  <= int'(v_nxt) >= V_SYNC;
            bright <= (int'(h_nxt) >= H_VIS_LO) && (int'(h_nxt) < H_VIS_HI) &&
                      (int'(v_nxt) >= V_VIS_LO) && (int'(v_nxt) < V_VIS_HI);
        end
    end
endmodule

// File: tb/tb_display_timing.sv
// Bench for display_timing: three parameterisations checked every cycle against an
// arithmetic raster model (pixel index = edges since release / CLK_DIV) under random async resets.
module tb_display_timing;
    logic clk = 1'b0;
    logic rst_a = 1'b0, rst_b = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] h_a, v_a, h_b, v_b, h_c, v_c;
    logic hs_a, vs_a, br_a, pe_a, ft_a;
    logic hs_b, vs_b, br_b, pe_b, ft_b;
    logic hs_c, vs_c, br_c, pe_c, ft_c;

    // a: default VGA; b: CLK_DIV=1 with 10x5 totals; c: CLK_DIV=2 small raster (shares rst_a)
    display_timing u_a (.clk(clk), .rst(rst_a), .hCount(h_a), .vCount(v_a), .hSync(hs_a),
                        .vSync(vs_a), .bright(br_a), .pix_en(pe_a), .frame_tick(ft_a));
    display_timing #(.CLK_DIV(1), .H_SYNC(2), .H_BP(1), .H_ACTIVE(5), .H_TOTAL(10),
                     .V_SYNC(1), .V_BP(1), .V_ACTIVE(2), .V_TOTAL(5))
        u_b (.clk(clk), .rst(rst_b), .hCount(h_b), .vCount(v_b), .hSync(hs_b),
             .vSync(vs_b), .bright(br_b), .pix_en(pe_b), .frame_tick(ft_b));
    display_timing #(.CLK_DIV(2), .H_SYNC(3), .H_BP(2), .H_ACTIVE(12), .H_TOTAL(20),
                     .V_SYNC(2), .V_BP(1), .V_ACTIVE(6), .V_TOTAL(12))
        u_c (.clk(clk), .rst(rst_a), .hCount(h_c), .vCount(v_c), .hSync(hs_c),
             .vSync(vs_c), .bright(br_c), .pix_en(pe_c), .frame_tick(ft_c));

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Edges seen since the last reset release.
    longint t_a = 0, t_b = 0;
    always @(posedge clk or negedge rst_a) if (!rst_a) t_a <= 0; else t_a <= t_a + 1;
    always @(posedge clk or negedge rst_b) if (!rst_b) t_b <= 0; else t_b <= t_b + 1;

    typedef struct {
        int h, v;
        bit hs, vs, br, pe, ft;
    } exp_t;

    function automatic exp_t model(longint t, logic r, int cd, int ht, int vt, int hsw, int hbp,
                                   int ha, int vsw, int vbp, int va);
        exp_t e;
        longint p = t / cd;
        e.h  = int'(p % ht);
        e.v  = int'((p / ht) % vt);
        e.hs = e.h >= hsw;
        e.vs = e.v >= vsw;
        e.br = (e.h >= hsw + hbp) && (e.h < hsw + hbp + ha) &&
               (e.v >= vsw + vbp) && (e.v < vsw + vbp + va);
        e.pe = r && ((t % cd) == cd - 1);
        e.ft = e.pe && (e.h == ht - 1) && (e.v == vt - 1);
        return e;
    endfunction

    task automatic chk_inst(input string n, input exp_t e, input logic [9:0] h, input logic [9:0] v,
                            input logic hs, input logic vs, input logic br, input logic pe,
                            input logic ft);
        chk({n, ".hCount"}, 32'(h), 32'(e.h));
        chk({n, ".vCount"}, 32'(v), 32'(e.v));
        chk({n, ".hSync"}, 32'(hs), 32'(e.hs));
        chk({n, ".vSync"}, 32'(vs), 32'(e.vs));
        chk({n, ".bright"}, 32'(br), 32'(e.br));
        chk({n, ".pix_en"}, 32'(pe), 32'(e.pe));
        chk({n, ".frame_tick"}, 32'(ft), 32'(e.ft));
    endtask

    int ft_cnt_b = 0, br_cnt_c = 0;
    always @(negedge clk) begin
        chk_inst("a", model(t_a, rst_a, 4, 800, 525, 96, 48, 640, 2, 33, 480),
                 h_a, v_a, hs_a, vs_a, br_a, pe_a, ft_a);
        chk_inst("b", model(t_b, rst_b, 1, 10, 5, 2, 1, 5, 1, 1, 2),
                 h_b, v_b, hs_b, vs_b, br_b, pe_b, ft_b);
        chk_inst("c", model(t_a, rst_a, 2, 20, 12, 3, 2, 12, 2, 1, 6),
                 h_c, v_c, hs_c, vs_c, br_c, pe_c, ft_c);
        if (ft_b) ft_cnt_b++;
        if (br_c) br_cnt_c++;
    end

    initial begin
        int sel;
        repeat (10) @(posedge clk);
        @(posedge clk); #2;
        rst_a = 1'b1; rst_b = 1'b1;
        // Release: pix_en first after the 3rd edge, hCount=1 after the 4th.
        repeat (2) @(posedge clk); #1;
        chk("rel.pix_en_e2", 32'(pe_a), 32'd0);
        @(posedge clk); #1;
        chk("rel.pix_en_e3", 32'(pe_a), 32'd1);
        chk("rel.h_e3", 32'(h_a), 32'd0);
        @(posedge clk); #1;
        chk("rel.h_e4", 32'(h_a), 32'd1);
        chk("rel.hSync_e4", 32'(hs_a), 32'd0);
        // Uninterrupted stretch: more than one full default line, many small frames.
        ft_cnt_b = 0;
        repeat (4000) @(posedge clk);
        #1;
        chk("b.frame_ticks_4000", 32'(ft_cnt_b), 32'd80);
        chk("c.bright_seen", 32'(br_cnt_c > 0), 32'd1);
        chk("a.vCount_line1", 32'(v_a), 32'd1);
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(20, 3000)) @(posedge clk);
            sel = $urandom_range(0, 2);
            #2;
            if (sel != 1) rst_a = 1'b0;
            if (sel != 0) rst_b = 1'b0;
            #1;
            if (sel != 1) begin
                chk("async.a.h", 32'(h_a), 32'd0);
                chk("async.a.v", 32'(v_a), 32'd0);
                chk("async.a.hSync", 32'(hs_a), 32'd0);
                chk("async.a.pix_en", 32'(pe_a), 32'd0);
                chk("async.c.bright", 32'(br_c), 32'd0);
            end
            if (sel != 0) begin
                chk("async.b.h", 32'(h_b), 32'd0);
                chk("async.b.vSync", 32'(vs_b), 32'd0);
                chk("async.b.pix_en", 32'(pe_b), 32'd0);
                chk("async.b.frame_tick", 32'(ft_b), 32'd0);
            end
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #2;
            rst_a = 1'b1; rst_b = 1'b1;
        end
        repeat (200) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
